// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: one regfile write per cycle from the ALU or the buffered LSU FIFO, ALU preferred with starvation bound.
// wb_* registered (ALU 1 cycle, LSU 1 cycle after pop); lsu_ready = FIFO not full, alu_stall only when the FIFO is forced to win.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [4:0]      ent_rd_q   [DEPTH];
  logic [XLEN-1:0] ent_data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic fifo_ne, force_pop, pop, push;
  logic [AW-1:0] slot;

  assign fifo_ne   = (count_q != '0);
  assign force_pop = fifo_ne && (starve_q == SW'(STARVE_MAX));
  assign lsu_ready = (count_q != CW'(DEPTH));
  assign alu_stall = alu_valid && force_pop;
  // rd == 0 completes the handshake but is never buffered
  assign push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = '0;
    wb_data_d = '0;
    starve_d  = '0;
    pop       = 1'b0;
    if (force_pop) begin
      pop       = 1'b1;
      wb_we_d   = 1'b1;
      wb_rd_d   = ent_rd_q[rd_ptr_q];
      wb_data_d = ent_data_q[rd_ptr_q];
    end else if (alu_valid) begin
      if (alu_rd != 5'd0) begin
        wb_we_d   = 1'b1;
        wb_rd_d   = alu_rd;
        wb_data_d = alu_data;
      end
      // not forcing with a non-empty FIFO implies starve_q < STARVE_MAX
      if (fifo_ne) starve_d = starve_q + SW'(1);
    end else if (fifo_ne) begin
      pop       = 1'b1;
      wb_we_d   = 1'b1;
      wb_rd_d   = ent_rd_q[rd_ptr_q];
      wb_data_d = ent_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    pending_mask = '0;
    slot         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + AW'(i);
      if (CW'(i) < count_q) pending_mask[ent_rd_q[slot]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= lsu_rd;
      ent_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_regfile_wb_arbiter;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, lsu_valid;
  logic [4:0]      alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            alu_stall, lsu_ready, wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     pending_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pending_mask(pending_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: a queue of buffered results and a count of ALU wins.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  initial begin
    int   sz;
    ent_t e;
    mq.delete(); m_starve = 0; m_we = 0; m_rd = 0; m_data = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); m_starve = 0; m_we = 0; m_rd = 0; m_data = 0;
      end else begin
        sz = mq.size();
        if (sz > 0 && m_starve == STARVE_MAX) begin
          e = mq.pop_front();
          m_we = 1; m_rd = e.rd; m_data = e.data; m_starve = 0;
        end else if (alu_valid) begin
          m_we   = (alu_rd != 0);
          m_rd   = m_we ? alu_rd : 5'd0;
          m_data = m_we ? alu_data : 32'd0;
          m_starve = (sz > 0) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
        end else if (sz > 0) begin
          e = mq.pop_front();
          m_we = 1; m_rd = e.rd; m_data = e.data; m_starve = 0;
        end else begin
          m_we = 0; m_rd = 0; m_data = 0; m_starve = 0;
        end
        if (lsu_valid && sz < DEPTH && lsu_rd != 0) begin
          e.rd = lsu_rd; e.data = lsu_data;
          mq.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_wb_we", {31'd0, wb_we}, {31'd0, m_we});
    check("model_wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
    check("model_wb_data", wb_data, m_data);
    check("model_pending_mask", pending_mask, model_mask());
    check("model_lsu_ready", {31'd0, lsu_ready}, {31'd0, (mq.size() < DEPTH)});
    check("model_alu_stall", {31'd0, alu_stall},
          {31'd0, (alu_valid && mq.size() > 0 && m_starve == STARVE_MAX)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] drain_mask [5];
    drain_mask[2] = 32'h18; drain_mask[3] = 32'h10; drain_mask[4] = 32'h00;

    // Reset with both sources asserted
    rst_n = 0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
    repeat (2) @(posedge clk);
    #3;
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mask", pending_mask, 32'd0);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
    #4 rst_n = 1;
    step();
    check("post_rst_wb_we", {31'd0, wb_we}, 32'd1);
    check("post_rst_wb_rd", {27'd0, wb_rd}, 32'd7);
    alu_valid = 0; lsu_valid = 0;
    repeat (3) step();

    // ALU alone
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    check("alu_wb_we", {31'd0, wb_we}, 32'd1);
    check("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("alu_wb_data", wb_data, 32'hDEADBEEF);
    step();
    check("alu_after_we", {31'd0, wb_we}, 32'd0);

    // Fill with ALU busy: 4 pushes, then forced pop
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(i); lsu_data = 32'(i * 32'h11);
      step();
    end
    lsu_valid = 0;
    check("fill_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    check("fill_mask", pending_mask, 32'h1E);
    check("fill_alu_stall", {31'd0, alu_stall}, 32'd1);
    step();
    alu_valid = 0;
    check("force_wb_we", {31'd0, wb_we}, 32'd1);
    check("force_wb_rd", {27'd0, wb_rd}, 32'd1);
    check("force_wb_data", wb_data, 32'h11);
    check("force_mask", pending_mask, 32'h1C);
    check("force_lsu_ready", {31'd0, lsu_ready}, 32'd1);

    // Drain with no bubbles
    for (int k = 2; k <= 4; k++) begin
      step();
      check("drain_wb_rd", {27'd0, wb_rd}, 32'(k));
      check("drain_wb_data", wb_data, 32'(k * 32'h11));
      check("drain_mask", pending_mask, drain_mask[k]);
    end
    step();
    check("drain_end_we", {31'd0, wb_we}, 32'd0);

    // rd = 0 on both sides
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h5A;
    step();
    lsu_valid = 0;
    check("lsu_rd0_mask", pending_mask, 32'd0);
    check("lsu_rd0_ready", {31'd0, lsu_ready}, 32'd1);
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFF;
    step();
    alu_valid = 0;
    check("alu_rd0_we", {31'd0, wb_we}, 32'd0);
    check("alu_rd0_data", wb_data, 32'd0);
    step();
    check("rd0_no_pop_we", {31'd0, wb_we}, 32'd0);

    // Full FIFO with simultaneous offer: pop but no push, then push next cycle
    alu_valid = 1; alu_rd = 5'd11; alu_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(6 + i); lsu_data = 32'(32'h66 + i * 32'h11);
      step();
    end
    alu_valid = 0;
    lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'hC0;
    check("full_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    step();
    check("full_pop_wb_rd", {27'd0, wb_rd}, 32'd6);
    check("full_nopush_mask", pending_mask, 32'h380);
    check("full_ready_back", {31'd0, lsu_ready}, 32'd1);
    step();
    check("full_push_wb_rd", {27'd0, wb_rd}, 32'd7);
    check("full_push_mask", pending_mask, 32'h1300);
    lsu_valid = 0;
    step();

    // Asynchronous reset mid-drain
    #2 rst_n = 0;
    #1;
    check("arst_wb_we", {31'd0, wb_we}, 32'd0);
    check("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    check("arst_mask", pending_mask, 32'd0);
    check("arst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1;
    repeat (3) step();
    check("post_arst_we", {31'd0, wb_we}, 32'd0);
    check("post_arst_mask", pending_mask, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
